// File: rtl/sha_state_bank_if.sv
// sha_state_bank_if: handshake carrying compression results into the chaining-state bank
interface sha_state_bank_if #(
    parameter int WIDTH = 32,
    parameter int WORDS = 8
);
    logic                   add_valid;
    logic                   add_ready;
    logic [WORDS*WIDTH-1:0] add_word;
    modport master (output add_valid, add_word, input add_ready);
    modport slave (input add_valid, add_word, output add_ready);
endinterface

// File: rtl/sha_state_bank.sv
// sha_state_bank: SHA-256 chaining-state bank sequencing header chunks and the second hash
// Define SHA_MIDSTATE_EN to keep the chunk-1 midstate so nonce sweeps can skip chunk 1.
module sha_state_bank #(
    parameter int WIDTH = 32,
    parameter int WORDS = 8,
    parameter logic [WORDS*WIDTH-1:0] IV = 256'h5be0cd19_1f83d9ab_9b05688c_510e527f_a54ff53a_3c6ef372_bb67ae85_6a09e667
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   reuse_mid,
    input  logic                   mid_clr,
    sha_state_bank_if.slave        bus,
    output logic [WORDS*WIDTH-1:0] h_out,
    output logic [WORDS*WIDTH-1:0] msg2,
    output logic [1:0]             phase,
    output logic                   busy,
    output logic                   mid_valid,
    output logic [WORDS*WIDTH-1:0] digest,
    output logic                   digest_valid
);
    typedef enum logic [1:0] {IDLE, CHUNK1, CHUNK2, HASH2} state_t;
    state_t                 state;
    logic [WORDS*WIDTH-1:0] sum;
    logic [WORDS*WIDTH-1:0] mid;
    logic                   acc;
    logic                   reuse;
    for (genvar i = 0; i < WORDS; i++) begin : g_add
        assign sum[i*WIDTH +: WIDTH] = h_out[i*WIDTH +: WIDTH] + bus.add_word[i*WIDTH +: WIDTH];
    end
    assign phase = state;
    assign busy = state != IDLE;
    assign bus.add_ready = busy;
    assign acc = bus.add_valid & bus.add_ready;
`ifdef SHA_MIDSTATE_EN
    assign reuse = reuse_mid & mid_valid;
    // a CHUNK1 write overrides a same-cycle clear; start suppresses the write
    always_ff @(posedge clk) begin
        if (rst) begin
            mid <= '0;
            mid_valid <= 1'b0;
        end else begin
            if (mid_clr) mid_valid <= 1'b0;
            if (acc && !start && state == CHUNK1) begin
                mid <= sum;
                mid_valid <= 1'b1;
            end
        end
    end
`else
    logic unused_mid;
    assign unused_mid = reuse_mid ^ mid_clr;
    assign reuse = 1'b0;
    assign mid = '0;
    assign mid_valid = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            h_out <= IV;
            msg2 <= '0;
            digest <= '0;
            digest_valid <= 1'b0;
        end else begin
            digest_valid <= 1'b0;
            if (start) begin
                state <= reuse ? CHUNK2 : CHUNK1;
                h_out <= reuse ? mid : IV;
            end else if (acc) begin
                case (state)
                    CHUNK1: begin
                        h_out <= sum;
                        state <= CHUNK2;
                    end
                    CHUNK2: begin
                        msg2 <= sum;
                        h_out <= IV;
                        state <= HASH2;
                    end
                    default: begin
                        digest <= sum;
                        digest_valid <= 1'b1;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_sha_state_bank.sv
// tb_sha_state_bank: directed vector table, corner sequences and randomized run against a reference model
module tb_sha_state_bank;
    localparam logic [255:0] IV = 256'h5be0cd19_1f83d9ab_9b05688c_510e527f_a54ff53a_3c6ef372_bb67ae85_6a09e667;
    localparam logic [31:0] I0 = 32'h6a09e667, I1 = 32'hbb67ae85, I2 = 32'h3c6ef372;
`ifdef SHA_MIDSTATE_EN
    localparam bit MID = 1'b1;
`else
    localparam bit MID = 1'b0;
`endif
    logic clk = 1'b0, rst = 1'b0, start = 1'b0, reuse_mid = 1'b0, mid_clr = 1'b0;
    logic [255:0] h_out, msg2, digest;
    logic [1:0] phase;
    logic busy, mid_valid, digest_valid;
    int checks = 0, errors = 0;
    sha_state_bank_if #(.WIDTH(32), .WORDS(8)) bus ();
    sha_state_bank dut (
        .clk(clk), .rst(rst), .start(start), .reuse_mid(reuse_mid), .mid_clr(mid_clr), .bus(bus),
        .h_out(h_out), .msg2(msg2), .phase(phase), .busy(busy), .mid_valid(mid_valid),
        .digest(digest), .digest_valid(digest_valid)
    );
    always #5 clk = ~clk;

    logic [255:0] mh, mmid, mmsg, mdig;
    int mph = 0;
    bit mmv = 0, mdv = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // reference: phase number plus word-wise modular sums
    task automatic model(input bit st, rm, mc, av, input logic [255:0] w, input bit r);
        logic [255:0] s;
        bit nmv;
        bit acc;
        acc = av && mph != 0;
        for (int i = 0; i < 8; i++) s[i*32 +: 32] = mh[i*32 +: 32] + w[i*32 +: 32];
        mdv = 0;
        if (r) begin
            mph = 0; mh = IV; mmid = '0; mmv = 0; mmsg = '0; mdig = '0;
        end else begin
            nmv = mmv && !(MID && mc);
            if (st) begin
                if (MID && rm && mmv) begin mh = mmid; mph = 2; end
                else begin mh = IV; mph = 1; end
            end else if (acc) begin
                if (mph == 1) begin mh = s; mmid = s; nmv = MID; mph = 2; end
                else if (mph == 2) begin mmsg = s; mh = IV; mph = 3; end
                else begin mdig = s; mdv = 1; mph = 0; end
            end
            mmv = nmv;
        end
    endtask

    task automatic step(input bit st, rm, mc, av, input logic [255:0] w, input bit r);
        start = st; reuse_mid = rm; mid_clr = mc; bus.add_valid = av; bus.add_word = w; rst = r;
        if (!r) check("add_ready", bus.add_ready, mph != 0);
        model(st, rm, mc, av, w, r);
        @(posedge clk);
        #1;
        check("phase", phase, mph);
        check("busy", busy, mph != 0);
        check("h_out", h_out, mh);
        check("msg2", msg2, mmsg);
        check("digest", digest, mdig);
        check("digest_valid", digest_valid, mdv);
        check("mid_valid", mid_valid, mmv);
    endtask

    typedef struct {
        bit st, rm, mc, av, r;
        logic [255:0] w;
        int ph;
        logic [31:0] h0, h1, h2, m2, dg;
        bit dv, mv;
    } vec_t;
    vec_t vq[$];

    function automatic void v(bit st, rm, mc, av, logic [255:0] w, bit r, int ph,
                              logic [31:0] h0, h1, h2, m2, dg, bit dv, mv);
        vec_t e;
        e.st = st; e.rm = rm; e.mc = mc; e.av = av; e.w = w; e.r = r; e.ph = ph;
        e.h0 = h0; e.h1 = h1; e.h2 = h2; e.m2 = m2; e.dg = dg; e.dv = dv; e.mv = mv;
        vq.push_back(e);
    endfunction

    initial begin
        logic [255:0] z, ones, wrap, rw;
        bit m;
        m = MID;
        z = '0;
        ones = {8{32'h1}};
        wrap = ones;
        wrap[31:0] = 32'h95f61999;
        bus.add_valid = 1'b0;
        bus.add_word = '0;
        v(0,0,0,0,z,1,    0, I0, I1, I2, 0, 0, 0, 0);
        v(0,0,0,0,z,1,    0, I0, I1, I2, 0, 0, 0, 0);
        v(1,0,0,0,z,0,    1, I0, I1, I2, 0, 0, 0, 0);
        v(0,0,0,1,ones,0, 2, I0+1, I1+1, I2+1, 0, 0, 0, m);
        v(0,0,0,1,ones,0, 3, I0, I1, I2, I2+2, 0, 0, m);
        v(0,0,0,1,ones,0, 0, I0, I1, I2, I2+2, I2+1, 1, m);
        v(0,0,0,0,z,0,    0, I0, I1, I2, I2+2, I2+1, 0, m);
        v(1,0,0,0,z,0,    1, I0, I1, I2, I2+2, I2+1, 0, m);
        v(0,0,0,1,wrap,0, 2, 32'h0, I1+1, I2+1, I2+2, I2+1, 0, m);
        v(0,0,0,1,ones,0, 3, I0, I1, I2, I2+2, I2+1, 0, m);
        v(0,0,0,1,ones,0, 0, I0, I1, I2, I2+2, I2+1, 1, m);
        v(1,1,0,0,z,0,    m ? 2 : 1, m ? 32'h0 : I0, I1+32'(m), I2+32'(m), I2+2, I2+1, 0, m);
        v(0,0,1,0,z,0,    m ? 2 : 1, m ? 32'h0 : I0, I1+32'(m), I2+32'(m), I2+2, I2+1, 0, 0);
        v(1,1,0,0,z,0,    1, I0, I1, I2, I2+2, I2+1, 0, 0);
        v(0,0,0,1,ones,0, 2, I0+1, I1+1, I2+1, I2+2, I2+1, 0, m);
        v(1,0,0,1,ones,0, 1, I0, I1, I2, I2+2, I2+1, 0, m);
        v(0,0,0,1,ones,0, 2, I0+1, I1+1, I2+1, I2+2, I2+1, 0, m);
        v(0,0,0,1,ones,0, 3, I0, I1, I2, I2+2, I2+1, 0, m);
        v(0,0,0,1,ones,1, 0, I0, I1, I2, 0, 0, 0, 0);
        v(0,0,0,0,z,0,    0, I0, I1, I2, 0, 0, 0, 0);
        @(negedge clk);
        foreach (vq[k]) begin
            step(vq[k].st, vq[k].rm, vq[k].mc, vq[k].av, vq[k].w, vq[k].r);
            check($sformatf("vec%0d_phase", k), phase, vq[k].ph);
            check($sformatf("vec%0d_h0", k), h_out[31:0], vq[k].h0);
            check($sformatf("vec%0d_h1", k), h_out[63:32], vq[k].h1);
            check($sformatf("vec%0d_h2", k), h_out[95:64], vq[k].h2);
            check($sformatf("vec%0d_msg2", k), msg2[95:64], vq[k].m2);
            check($sformatf("vec%0d_digest", k), digest[95:64], vq[k].dg);
            check($sformatf("vec%0d_dvalid", k), digest_valid, vq[k].dv);
            check($sformatf("vec%0d_mvalid", k), mid_valid, vq[k].mv);
        end
        // mid_clr colliding with a CHUNK1 write, then reuse alongside a clear
        step(1,0,0,0,z,0);
        step(0,0,1,1,ones,0);
        check("clr_vs_chunk1_mv", mid_valid, MID);
        step(1,1,1,0,z,0);
        check("reuse_preclear_phase", phase, MID ? 2 : 1);
        check("reuse_preclear_h2", h_out[95:64], MID ? I2+1 : I2);
        check("reuse_preclear_mv", mid_valid, 1'b0);
        for (int n = 0; n < 800; n++) begin
            for (int i = 0; i < 8; i++) rw[i*32 +: 32] = $urandom;
            step($urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 3) != 0, rw, $urandom_range(0, 60) == 0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sha_state_bank.md
# sha_state_bank

Parametrised SHA-256 chaining-state bank for the mining datapath: holds all WORDS hash words, sequences a two-chunk header hash followed by the second (double-SHA) hash, and adds each compression result to the chaining value modulo 2^WIDTH per word. It sits between the message scheduler/compression core and the nonce comparator. It also keeps the header midstate so that nonce sweeps skip chunk 1.

## Interface
Parameters:
- WIDTH, 32, bits per hash word.
- WORDS, 8, number of chaining words.
- IV, {5be0cd19,1f83d9ab,9b05688c,510e527f,a54ff53a,3c6ef372,bb67ae85,6a09e667}, initial value with H0 in the LSBs.

Ports (word i occupies bits [i*WIDTH +: WIDTH]):
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a new header hash.
- reuse_mid  in  1  sampled with start; use the saved midstate and skip chunk 1.
- mid_clr  in  1  invalidate the saved midstate.
- add_valid  in  1  compression result is valid.
- add_ready  out  1  bank accepts the result.
- add_word  in  WORDS*WIDTH  compression working variables a..h.
- h_out  out  WORDS*WIDTH  current chaining value fed to the core.
- msg2  out  WORDS*WIDTH  first-hash digest, the message for the second hash.
- phase  out  2  0=IDLE, 1=CHUNK1, 2=CHUNK2, 3=HASH2.
- busy  out  1  phase != 0.
- mid_valid  out  1  midstate register holds a valid chunk-1 result.
- digest  out  WORDS*WIDTH  final double-hash digest.
- digest_valid  out  1  one-cycle pulse when digest is updated.

## Operation
- Word arithmetic: h[i] + add[i] is truncated to WIDTH bits. There is no carry between words.
- add_ready = 1 in CHUNK1, CHUNK2 and HASH2, and 0 in IDLE. It is decoded combinationally from the state.
- An accept is add_valid & add_ready on a rising edge.
- IDLE, on start:
  - h <= IV and the state goes to CHUNK1.
  - If reuse_mid & mid_valid (and the macro is present), h <= mid and the state goes to CHUNK2 instead.
- CHUNK1, on accept: h <= h+add; mid <= h+add; mid_valid <= 1; go to CHUNK2.
- CHUNK2, on accept: msg2 <= h+add; h <= IV; go to HASH2.
- HASH2, on accept: digest <= h+add; digest_valid <= 1 for the next cycle only; go to IDLE. h stays at IV.
- start restarts the sequence from any state.
  - start has priority over a same-cycle accept. That add is discarded and none of h, mid or msg2 is updated from it.
- mid_clr: mid_valid <= 0 next cycle.
  - If mid_clr and a CHUNK1 accept occur together, the CHUNK1 write wins and mid_valid = 1.
  - A start with reuse_mid in the same cycle as mid_clr uses the pre-clear mid_valid.
- Reset values:
  - state IDLE, phase 0, busy 0, add_ready 0.
  - h_out = IV.
  - mid = 0, mid_valid = 0, msg2 = 0, digest = 0, digest_valid = 0.
- Reset in the middle of a sequence abandons it. No digest_valid is produced.

## Timing
- An accept updates h_out, msg2 and mid in the following cycle. Back-to-back accepts in consecutive cycles are legal.
- Latency from the HASH2 accept to digest_valid is 1 cycle. digest is held until the next HASH2 accept or rst.
- phase changes in the cycle after start or after an accept.
- start with reuse_mid set shows phase=2 and h_out=mid in the next cycle.
- Minimum sequence length: 1 cycle (start), then 3 accepts for a full sequence, or 2 accepts with midstate reuse.

## Configuration
- SHA_MIDSTATE_EN defined: the mid register, mid_valid, mid_clr and reuse_mid are functional as above.
- SHA_MIDSTATE_EN undefined:
  - No mid register is built and mid_valid is tied to 0.
  - reuse_mid and mid_clr are ignored.
  - Every start enters CHUNK1.

## Test plan
- rst for 2 cycles -> h_out=IV (word2=3c6ef372), phase=0, add_ready=0, digest_valid=0, mid_valid=0.
- start, then three accepts, each with every add word = 00000001:
  - After CHUNK1: h word2 = 3c6ef373, mid_valid=1.
  - After CHUNK2: msg2 word2 = 3c6ef374 and h_out = IV.
  - After HASH2: digest word2 = 3c6ef373, digest_valid high for exactly 1 cycle, phase=0.
- Wrap-around: add word0 = 95f61999 in CHUNK1 -> h word0 = 00000000 and word1 = bb67ae86, with no carry into word1.
- Midstate reuse after the previous test: start with reuse_mid=1 -> next cycle phase=2 and h_out word2 = 3c6ef373.
  - Same stimulus after mid_clr -> phase=1 and h_out = IV.
  - Same stimulus with the macro undefined -> phase=1.
- In CHUNK2, start and add_valid in the same cycle -> add discarded, phase=1, h_out=IV, msg2 unchanged.
- rst asserted during HASH2 together with add_valid -> phase=0 and digest_valid never asserts.
